// File: rtl/wb_commit_queue.sv
// Ordered writeback queue: merges ALU and MDU results into the single GRF write port,
// one commit per cycle, and forwards still-pending values to decode.
module wb_commit_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_addr,
    input  logic [DW-1:0]              alu_data,
    input  logic [31:0]                alu_pc,
    input  logic                       mdu_valid,
    input  logic [AW-1:0]              mdu_addr,
    input  logic [DW-1:0]              mdu_data,
    input  logic [31:0]                mdu_pc,
    output logic                       in_ready,
    output logic                       grf_we,
    output logic [AW-1:0]              grf_a3,
    output logic [DW-1:0]              grf_wd,
    output logic [31:0]                grf_pc,
    input  logic [AW-1:0]              rd_a1,
    input  logic [AW-1:0]              rd_a2,
    output logic                       fwd1_hit,
    output logic [DW-1:0]              fwd1_data,
    output logic                       fwd2_hit,
    output logic [DW-1:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [31:0]   ent_pc   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          alu_acc;
    logic          mdu_acc;
    logic          pop;
    logic [PW-1:0] mdu_slot;

    // Capacity uses the registered count; the same-cycle pop is deliberately not credited.
    assign alu_acc  = !rst && alu_valid && (count < DEPTH_C);
    assign mdu_acc  = !rst && mdu_valid && ((count + CW'(alu_acc)) < DEPTH_C);
    assign pop      = !rst && (count != '0);
    assign mdu_slot = tail + PW'(alu_acc);

    assign in_ready = rst || (count <= (DEPTH_C - CW'(2)));
    assign grf_we   = pop;
    assign grf_a3   = (count != '0) ? ent_addr[head] : '0;
    assign grf_wd   = (count != '0) ? ent_data[head] : '0;
    assign grf_pc   = (count != '0) ? ent_pc[head]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (alu_acc) begin
                ent_addr[tail] <= alu_addr;
                ent_data[tail] <= alu_data;
                ent_pc[tail]   <= alu_pc;
            end
            if (mdu_acc) begin
                ent_addr[mdu_slot] <= mdu_addr;
                ent_data[mdu_slot] <= mdu_data;
                ent_pc[mdu_slot]   <= mdu_pc;
            end
            if ((alu_valid && !alu_acc) || (mdu_valid && !mdu_acc)) begin
                overflow <= 1'b1;
            end
            tail  <= tail + PW'(alu_acc) + PW'(mdu_acc);
            head  <= head + PW'(pop);
            count <= count + CW'(alu_acc) + CW'(mdu_acc) - CW'(pop);
        end
    end

    // Walk oldest to youngest so the last match is the youngest; address 0 never forwards.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (!rst && (CW'(i) < count)) begin
                if ((rd_a1 != '0) && (ent_addr[idx] == rd_a1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = ent_data[idx];
                end
                if ((rd_a2 != '0) && (ent_addr[idx] == rd_a2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = ent_data[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue with hand-computed expectations.
module tb_wb_commit_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic [31:0] alu_pc;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        in_ready;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [2:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_fails  = 0;

    wb_commit_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_pc(alu_pc),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_pc(mdu_pc),
        .in_ready(in_ready), .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .rd_a1(rd_a1), .rd_a2(rd_a2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        alu_valid = 1'b1; alu_addr = a; alu_data = d; alu_pc = p;
    endtask

    task automatic mdu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        mdu_valid = 1'b1; mdu_addr = a; mdu_data = d; mdu_pc = p;
    endtask

    task automatic idle();
        alu_valid = 1'b0; mdu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alu_addr = '0; alu_data = '0; alu_pc = '0;
        mdu_addr = '0; mdu_data = '0; mdu_pc = '0;
        rd_a1 = '0; rd_a2 = '0;
        step();
        step();
        chk("rst_we",       32'(grf_we),   32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_fwd1",     32'(fwd1_hit), 32'd0);
        rst = 1'b0;
        step();

        // Single ALU push, committed the next cycle.
        alu(5'd5, 32'h11, 32'h3000);
        rd_a1 = 5'd5;
        step();
        idle();
        #1;
        chk("t1_we",   32'(grf_we),  32'd1);
        chk("t1_a3",   32'(grf_a3),  32'd5);
        chk("t1_wd",   grf_wd,       32'h11);
        chk("t1_pc",   grf_pc,       32'h3000);
        chk("t1_fwd",  fwd1_data,    32'h11);
        step();
        chk("t1_empty_we", 32'(grf_we), 32'd0);
        chk("t1_empty_a3", 32'(grf_a3), 32'd0);
        chk("t1_count",    32'(count),  32'd0);

        // Same-cycle ALU and MDU to the same register.
        alu(5'd3, 32'hA, 32'h3004);
        mdu(5'd3, 32'hB, 32'h3008);
        step();
        idle();
        rd_a1 = 5'd3;
        #1;
        chk("t2_count",    32'(count),    32'd2);
        chk("t2_wd0",      grf_wd,        32'hA);
        chk("t2_pc0",      grf_pc,        32'h3004);
        chk("t2_fwd_hit",  32'(fwd1_hit), 32'd1);
        chk("t2_fwd_data", fwd1_data,     32'hB);
        step();
        chk("t2_wd1",      grf_wd,        32'hB);
        chk("t2_pc1",      grf_pc,        32'h3008);
        chk("t2_fwd_data1", fwd1_data,    32'hB);
        step();
        chk("t2_empty",    32'(grf_we),   32'd0);
        chk("t2_fwd_miss", 32'(fwd1_hit), 32'd0);

        // Dual pushes until in_ready drops, then forced pushes that overflow.
        alu(5'd1, 32'h21, 32'h4000);
        mdu(5'd2, 32'h22, 32'h4004);
        step();
        chk("t3_count2",  32'(count),    32'd2);
        chk("t3_ready2",  32'(in_ready), 32'd1);
        alu(5'd3, 32'h23, 32'h4008);
        mdu(5'd4, 32'h24, 32'h400C);
        step();
        chk("t3_count3",  32'(count),    32'd3);
        chk("t3_ready3",  32'(in_ready), 32'd0);
        chk("t3_head22",  grf_wd,        32'h22);
        chk("t3_ovf0",    32'(overflow), 32'd0);
        alu(5'd5, 32'h25, 32'h4010);
        mdu(5'd6, 32'h26, 32'h4014);
        rd_a2 = 5'd6;
        step();
        chk("t3_ovf1",     32'(overflow), 32'd1);
        chk("t3_count_c",  32'(count),    32'd3);
        chk("t3_head23",   grf_wd,        32'h23);
        chk("t3_drop_fwd", 32'(fwd2_hit), 32'd0);
        alu(5'd7, 32'h27, 32'h4018);
        mdu(5'd8, 32'h28, 32'h401C);
        step();
        idle();
        rd_a2 = 5'd0;
        #1;
        chk("t3_head24", grf_wd, 32'h24);
        step();
        chk("t3_head25", grf_wd, 32'h25);
        step();
        chk("t3_head27", grf_wd, 32'h27);
        chk("t3_pc27",   grf_pc, 32'h4018);
        step();
        chk("t3_drained",  32'(grf_we),   32'd0);
        chk("t3_ovf_stky", 32'(overflow), 32'd1);

        // Register 0 commits but never forwards.
        alu(5'd0, 32'hFF, 32'h5000);
        rd_a1 = 5'd0;
        step();
        idle();
        #1;
        chk("t4_we",  32'(grf_we),   32'd1);
        chk("t4_a3",  32'(grf_a3),   32'd0);
        chk("t4_wd",  grf_wd,        32'hFF);
        chk("t4_fwd", 32'(fwd1_hit), 32'd0);
        step();

        // Reset with entries pending discards them.
        alu(5'd9, 32'h31, 32'h6000);
        mdu(5'd10, 32'h32, 32'h6004);
        step();
        alu(5'd11, 32'h33, 32'h6008);
        mdu(5'd12, 32'h34, 32'h600C);
        step();
        idle();
        #1;
        chk("t5_count3", 32'(count), 32'd3);
        rst = 1'b1;
        rd_a1 = 5'd11;
        #1;
        chk("t5_rst_we",  32'(grf_we),   32'd0);
        chk("t5_rst_fwd", 32'(fwd1_hit), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_count0",   32'(count),    32'd0);
        chk("t5_ovf_clr",  32'(overflow), 32'd0);
        chk("t5_we_after", 32'(grf_we),   32'd0);
        step();
        chk("t5_we_later", 32'(grf_we),   32'd0);

        // Ten single pushes, one per cycle: pointers wrap, commits stay in order.
        for (int i = 0; i < 10; i++) begin
            alu(5'(i + 1), 32'h100 + 32'(i), 32'h7000 + 32'(4 * i));
            step();
            chk("t6_we",    32'(grf_we), 32'd1);
            chk("t6_wd",    grf_wd,      32'h100 + 32'(i));
            chk("t6_a3",    32'(grf_a3), 32'(i + 1));
            chk("t6_count", 32'(count),  32'd1);
        end
        idle();
        step();
        chk("t6_end_count", 32'(count),  32'd0);
        chk("t6_end_we",    32'(grf_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
